// File: rtl/add_share_pkg.sv
// Shared types and helpers for the add_share_arbiter slice.
package add_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Index width for a requester count; a single requester still gets one bit.
    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping.
module rr_pick
    import add_share_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDW = idw(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic           w_found;
    logic [IDW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IDW'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_valid[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin shared WIDTH-bit adder with multi-word carry chaining and a registered result stage.
// Optional build macro ADD_SHARE_SUB_EN adds per-requester subtract (port req_sub).
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32,
    localparam int IDW  = idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_last,
`ifdef ADD_SHARE_SUB_EN
    input  logic [NREQ-1:0]       req_sub,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_last
);

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_owner;
    logic             r_carry;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_last;

    logic [NREQ-1:0]  w_owner_oh;
    logic [NREQ-1:0]  w_elig;
    logic [IDW-1:0]   w_ptr;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_can_take;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_last;
    logic             w_sub;
    logic             w_cin;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] idx);
        if (idx == IDW'(NREQ - 1)) return '0;
        return idx + IDW'(1);
    endfunction

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_owner_oh[i] = (r_owner == IDW'(i));
        end
    end

    // While locked only the owner is eligible; the picker then trivially selects it.
    assign w_elig = (r_state == LOCK) ? (req_valid & w_owner_oh) : req_valid;
    assign w_ptr  = (r_state == LOCK) ? r_owner : r_rr_ptr;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_valid (w_elig),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_can_take = !r_rsp_valid || rsp_ready;
    assign w_accept   = w_any && w_can_take;
    assign req_ready  = w_grant & {NREQ{w_accept & rst_n}};

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_a    = req_a[i*WIDTH +: WIDTH];
                w_b    = req_b[i*WIDTH +: WIDTH];
                w_last = req_last[i];
            end
        end
    end

`ifdef ADD_SHARE_SUB_EN
    logic r_sub;
    logic w_sub_in;

    always_comb begin
        w_sub_in = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) w_sub_in = req_sub[i];
        end
    end

    // Subtract mode is latched on the first word and held for the whole lock.
    assign w_sub = (r_state == LOCK) ? r_sub : w_sub_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (w_accept && r_state == IDLE) begin
            r_sub <= w_sub_in;
        end
    end
`else
    assign w_sub = 1'b0;
`endif

    // First word of a subtract injects the +1 of the two's complement.
    assign w_cin   = (r_state == LOCK) ? r_carry : w_sub;
    assign w_b_eff = w_sub ? ~w_b : w_b;
    assign {w_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_carry     <= w_cout;
                r_rsp_valid <= 1'b1;
                r_rsp_sum   <= w_sum;
                r_rsp_cout  <= w_cout;
                r_rsp_id    <= w_idx;
                r_rsp_last  <= w_last;
                case (r_state)
                    IDLE: begin
                        if (w_last) begin
                            r_rr_ptr <= f_next(w_idx);
                        end else begin
                            r_state <= LOCK;
                            r_owner <= w_idx;
                        end
                    end
                    LOCK: begin
                        if (w_last) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= f_next(r_owner);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter with a transaction-level reference model checked every cycle.
module tb_add_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [63:0]     req_a;
    logic [63:0]     req_b;
    logic [1:0]      req_last;
`ifdef ADD_SHARE_SUB_EN
    logic [1:0]      req_sub;
`endif
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;
    logic [0:0]      rsp_id;
    logic            rsp_last;

    int total;
    int bad;

    add_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
`ifdef ADD_SHARE_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (operation-level view) ----------------
    bit          m_lock, n_lock;
    int          m_owner, n_owner;
    int          m_ptr, n_ptr;
    bit          m_carry, n_carry;
    bit          m_sub, n_sub;
    bit          m_rv, n_rv;
    logic [31:0] m_sum, n_sum;
    bit          m_cout, n_cout;
    int          m_id, n_id;
    bit          m_last, n_last;

    always @(negedge clk) begin
        int          win;
        bit          take;
        bit          sub;
        bit          cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] s;
        logic [1:0]  exp_rdy;
        if (!rst_n) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_req_ready", req_ready, 0);
        end else begin
            check("m_rsp_valid", rsp_valid, m_rv);
            if (m_rv) begin
                check("m_rsp_sum", rsp_sum, m_sum);
                check("m_rsp_cout", rsp_cout, m_cout);
                check("m_rsp_id", rsp_id, m_id);
                check("m_rsp_last", rsp_last, m_last);
            end
            take = !m_rv || rsp_ready;
            win  = -1;
            if (m_lock) begin
                if (req_valid[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
                end
            end
            exp_rdy = (take && win >= 0) ? (2'b01 << win) : 2'b00;
            check("m_req_ready", req_ready, exp_rdy);

            n_lock = m_lock; n_owner = m_owner; n_ptr = m_ptr; n_carry = m_carry;
            n_sub = m_sub; n_rv = m_rv; n_sum = m_sum; n_cout = m_cout;
            n_id = m_id; n_last = m_last;
            if (take && win >= 0) begin
                a = req_a[win*32 +: 32];
                b = req_b[win*32 +: 32];
`ifdef ADD_SHARE_SUB_EN
                sub = m_lock ? m_sub : req_sub[win];
`else
                sub = 1'b0;
`endif
                cin = m_lock ? m_carry : sub;
                s = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, cin};
                n_rv = 1; n_sum = s[31:0]; n_cout = s[32]; n_carry = s[32];
                n_id = win; n_last = req_last[win];
                if (req_last[win]) begin
                    n_lock = 0;
                    n_ptr  = (win + 1) % NREQ;
                end else begin
                    n_lock  = 1;
                    n_owner = win;
                    n_sub   = sub;
                end
            end else if (rsp_ready) begin
                n_rv = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_lock = 0; m_owner = 0; m_ptr = 0; m_carry = 0; m_sub = 0;
            m_rv = 0; m_sum = '0; m_cout = 0; m_id = 0; m_last = 0;
        end else begin
            m_lock = n_lock; m_owner = n_owner; m_ptr = n_ptr; m_carry = n_carry;
            m_sub = n_sub; m_rv = n_rv; m_sum = n_sum; m_cout = n_cout;
            m_id = n_id; m_last = n_last;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_is(input string name, input logic [31:0] sum, input logic cout,
                          input logic id, input logic last);
        check({name, "_valid"}, rsp_valid, 1);
        check({name, "_sum"}, rsp_sum, sum);
        check({name, "_cout"}, rsp_cout, cout);
        check({name, "_id"}, rsp_id, id);
        check({name, "_last"}, rsp_last, last);
    endtask

    initial begin
        logic [31:0] held_sum;
        logic        held_id;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_valid = 2'b01;
        req_a = {32'd3, 32'd4};
        req_b = {32'd5, 32'd6};
        req_last = 2'b11;
        rsp_ready = 1'b1;
`ifdef ADD_SHARE_SUB_EN
        req_sub = 2'b00;
`endif
        step(); step();
        check("reset_valid", rsp_valid, 0);
        check("reset_sum", rsp_sum, 0);
        check("reset_cout", rsp_cout, 0);
        check("reset_id", rsp_id, 0);
        check("reset_last", rsp_last, 0);
        check("reset_ready", req_ready, 0);

        // Single word from r0
        req_valid = 2'b00;
        rst_n = 1'b1;
        step();
        req_valid = 2'b01;
        req_a[31:0] = 32'hFFFF_FFFF; req_b[31:0] = 32'd1; req_last = 2'b11;
        #1 check("t1_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1 rsp_is("t1", 32'h0, 1'b1, 1'b0, 1'b1);

        // 64-bit op from r1 while r0 waits
        step();
        req_valid = 2'b11;
        req_a[63:32] = 32'hFFFF_FFFF; req_b[63:32] = 32'd1; req_last = 2'b01;
        #1 check("t2_lo_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b01;
        #1 rsp_is("t2_lo", 32'h0, 1'b1, 1'b1, 1'b0);
        check("t2_gap_ready", req_ready, 2'b00);
        step();
        req_valid = 2'b11;
        req_a[63:32] = 32'd0; req_b[63:32] = 32'd0; req_last = 2'b11;
        #1 check("t2_hi_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b01;
        #1 rsp_is("t2_hi", 32'h1, 1'b0, 1'b1, 1'b1);
        check("t2_r0_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b10;
        req_a[63:32] = 32'd10; req_b[63:32] = 32'd20;
        step();
        req_valid = 2'b00;
        step();

        // Round robin from rr_ptr=0
        req_a = {32'd3, 32'd1}; req_b = {32'd4, 32'd2}; req_last = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            rsp_is("t3_rr", (i % 2) ? 32'd7 : 32'd3, 1'b0, 1'((i % 2)), 1'b1);
        end

        // Backpressure with result pending
        rsp_ready = 1'b0;
        #1 check("t4_ready_blocked", req_ready, 2'b00);
        held_sum = rsp_sum;
        held_id  = rsp_id;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_sum", rsp_sum, held_sum);
            check("t4_hold_id", rsp_id, held_id);
            check("t4_hold_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        #1 check("t4_drain_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1 rsp_is("t4_next", 32'd3, 1'b0, 1'b0, 1'b1);
        step();

        // Reset in the middle of a locked operation
        req_valid = 2'b01;
        req_a[31:0] = 32'hFFFF_FFFF; req_b[31:0] = 32'd1; req_last = 2'b10;
        step();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1 check("t5_rst_valid", rsp_valid, 0);
        step();
        rst_n = 1'b1;
        req_valid = 2'b01;
        req_a[31:0] = 32'd5; req_b[31:0] = 32'd6; req_last = 2'b11;
        #1 check("t5_new_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1 rsp_is("t5_new", 32'd11, 1'b0, 1'b0, 1'b1);
        step();

`ifdef ADD_SHARE_SUB_EN
        req_sub = 2'b01;
        req_valid = 2'b01;
        req_a[31:0] = 32'd5; req_b[31:0] = 32'd7; req_last = 2'b11;
        step();
        req_valid = 2'b00;
        #1 rsp_is("t6_sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        step();
        req_valid = 2'b01;
        req_a[31:0] = 32'd0; req_b[31:0] = 32'd1; req_last = 2'b10;
        step();
        req_sub = 2'b00;
        req_a[31:0] = 32'd1; req_b[31:0] = 32'd0; req_last = 2'b11;
        #1 rsp_is("t6_lo", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step();
        req_valid = 2'b00;
        #1 rsp_is("t6_hi", 32'h0, 1'b1, 1'b0, 1'b1);
        step();
`endif

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
